// File: rtl/weight_loader.sv
// Weight tile loader: streams weight rows into MAC preweight registers, one-hot row select,
// then issues a single load_weight pulse once the tile is complete and the array permits a swap.
module weight_loader #(
    parameter  int MATRIX_WIDTH        = 14,
    parameter  int ROW_CNT_WIDTH       = $clog2(MATRIX_WIDTH),
    localparam int EXTENDED_BYTE_WIDTH = 9
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        weight_valid,
    output logic                                        weight_ready,
    input  logic [MATRIX_WIDTH*8-1:0]                   weight_row_in,
    input  logic                                        weight_signed,
    input  logic                                        swap_allowed,
    output logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] weight_out,
    output logic [MATRIX_WIDTH-1:0]                     preload_weight,
    output logic                                        load_weight,
    output logic                                        tile_loaded,
    output logic [ROW_CNT_WIDTH-1:0]                    row_count
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam logic [ROW_CNT_WIDTH-1:0] LAST_ROW = ROW_CNT_WIDTH'(MATRIX_WIDTH - 1);

    state_t                                        r_state;
    state_t                                        w_state_next;
    logic                                          w_accept;
    logic [ROW_CNT_WIDTH-1:0]                      r_row_count;
    logic [MATRIX_WIDTH-1:0]                       r_preload;
    logic [MATRIX_WIDTH-1:0]                       w_onehot;
    logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0]   r_weight_out;
    logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0]   w_ext_row;

    function automatic logic [EXTENDED_BYTE_WIDTH-1:0] extend_byte(input logic [7:0] b,
                                                                   input logic       is_signed);
        logic signed [7:0] sb;
        sb = b;
        return is_signed ? {sb[7], sb} : {1'b0, b};
    endfunction

    assign weight_ready   = (r_state == FILL) || (r_state == SWAP);
    assign tile_loaded    = (r_state == WAIT);
    assign load_weight    = (r_state == SWAP);
    assign w_accept       = weight_valid & weight_ready;
    assign weight_out     = r_weight_out;
    assign preload_weight = r_preload;
    assign row_count      = r_row_count;

    always_comb begin
        w_ext_row = '0;
        w_onehot  = '0;
        for (int j = 0; j < MATRIX_WIDTH; j++) begin
            w_ext_row[j*EXTENDED_BYTE_WIDTH +: EXTENDED_BYTE_WIDTH] =
                extend_byte(weight_row_in[j*8 +: 8], weight_signed);
            w_onehot[j] = (r_row_count == ROW_CNT_WIDTH'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DRAIN keeps the final preload pulse apart from load_weight.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_accept && (r_row_count == LAST_ROW)) w_state_next = DRAIN;
            DRAIN:   w_state_next = WAIT;
            WAIT:    if (swap_allowed) w_state_next = SWAP;
            SWAP:    w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_count  <= '0;
            r_preload    <= '0;
            r_weight_out <= '0;
        end else begin
            r_preload <= w_accept ? w_onehot : '0;
            if (w_accept) begin
                r_weight_out <= w_ext_row;
                r_row_count  <= (r_row_count == LAST_ROW) ? '0 : r_row_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a tile-progress model.
module tb_weight_loader;

    localparam int MW = 4;
    localparam int EW = 9;
    localparam int RW = $clog2(MW);

    logic              clk = 1'b0;
    logic              rst;
    logic              weight_valid;
    logic              weight_ready;
    logic [MW*8-1:0]   weight_row_in;
    logic              weight_signed;
    logic              swap_allowed;
    logic [MW*EW-1:0]  weight_out;
    logic [MW-1:0]     preload_weight;
    logic              load_weight;
    logic              tile_loaded;
    logic [RW-1:0]     row_count;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model: rows accepted in current tile, cycles since tile completed, swap cycle flag.
    int               m_rows = 0;
    int               m_gap  = 0;
    bit               m_swap = 1'b0;
    logic [MW-1:0]    m_pre  = '0;
    logic [MW*EW-1:0] m_wout = '0;

    weight_loader #(.MATRIX_WIDTH(MW)) dut (
        .clk            (clk),
        .rst            (rst),
        .weight_valid   (weight_valid),
        .weight_ready   (weight_ready),
        .weight_row_in  (weight_row_in),
        .weight_signed  (weight_signed),
        .swap_allowed   (swap_allowed),
        .weight_out     (weight_out),
        .preload_weight (preload_weight),
        .load_weight    (load_weight),
        .tile_loaded    (tile_loaded),
        .row_count      (row_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW*EW-1:0] ext_row(input logic [MW*8-1:0] r, input logic s);
        logic [MW*EW-1:0] o;
        logic [7:0]       b;
        int               v;
        o = '0;
        for (int j = 0; j < MW; j++) begin
            b = r[j*8 +: 8];
            v = s ? int'($signed(b)) : int'(b);
            o[j*EW +: EW] = EW'(v);
        end
        return o;
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit sw_next;
        if (rst) begin
            m_rows = 0;
            m_gap  = 0;
            m_swap = 1'b0;
            m_pre  = '0;
            m_wout = '0;
        end else begin
            acc     = weight_valid && (m_rows < MW);
            sw_next = (m_rows == MW) && (m_gap >= 1) && swap_allowed;
            m_pre   = '0;
            if (acc) begin
                m_pre  = MW'(1 << m_rows);
                m_wout = ext_row(weight_row_in, weight_signed);
                m_rows++;
                if (m_rows == MW) m_gap = 0;
            end else if (m_rows == MW && m_gap < 2) begin
                m_gap++;
            end
            m_swap = sw_next;
            if (sw_next) begin
                m_rows = 0;
                m_gap  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ready",   64'(weight_ready),   64'(m_rows < MW));
            chk("model_tile",    64'(tile_loaded),    64'((m_rows == MW) && (m_gap >= 1)));
            chk("model_load",    64'(load_weight),    64'(m_swap));
            chk("model_preload", 64'(preload_weight), 64'(m_pre));
            chk("model_wout",    64'(weight_out),     64'(m_wout));
            chk("model_rowcnt",  64'(row_count),      64'(m_rows % MW));
            if (load_weight && (preload_weight != '0)) begin
                chk("load_with_preload", 64'(preload_weight), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input logic v, input logic [MW*8-1:0] r, input logic s);
        weight_valid  = v;
        weight_row_in = r;
        weight_signed = s;
    endtask

    initial begin
        logic [MW*EW-1:0] held;
        rst = 1'b1;
        weight_valid = 1'b0;
        weight_row_in = '0;
        weight_signed = 1'b0;
        swap_allowed = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_ready",   64'(weight_ready),   64'd1);
        chk("rst_preload", 64'(preload_weight), 64'd0);
        chk("rst_wout",    64'(weight_out),     64'd0);
        chk("rst_load",    64'(load_weight),    64'd0);
        chk("rst_tile",    64'(tile_loaded),    64'd0);
        chk("rst_rowcnt",  64'(row_count),      64'd0);
        rst = 1'b0;

        // Full tile, swap allowed throughout.
        swap_allowed = 1'b1;
        for (int i = 0; i < MW; i++) begin
            drive_row(1'b1, MW*8'($urandom), 1'($urandom));
            step();
            chk("t1_preload", 64'(preload_weight), 64'(1 << i));
            chk("t1_noload",  64'(load_weight),    64'd0);
        end
        drive_row(1'b0, '0, 1'b0);
        chk("t1_drain_ready", 64'(weight_ready), 64'd0);
        step();
        chk("t1_wait_tile", 64'(tile_loaded), 64'd1);
        chk("t1_wait_load", 64'(load_weight), 64'd0);
        step();
        chk("t1_swap_load",    64'(load_weight),    64'd1);
        chk("t1_swap_preload", 64'(preload_weight), 64'd0);
        step();
        chk("t1_after_load",  64'(load_weight),  64'd0);
        chk("t1_after_ready", 64'(weight_ready), 64'd1);

        // Extension: bytes 80,80,7F,00 signed then unsigned.
        swap_allowed = 1'b0;
        drive_row(1'b1, 32'h007F8080, 1'b1);
        step();
        chk("t2_s80",  64'(weight_out[8:0]),   64'h180);
        chk("t2_s7f",  64'(weight_out[26:18]), 64'h07F);
        drive_row(1'b1, 32'h007F8080, 1'b0);
        step();
        chk("t2_u80",  64'(weight_out[8:0]),   64'h080);
        chk("t2_u7f",  64'(weight_out[26:18]), 64'h07F);
        chk("t2_pre",  64'(preload_weight),    64'b0010);

        // Two idle cycles mid-tile.
        held = weight_out;
        drive_row(1'b0, 32'hDEADBEEF, 1'b1);
        step();
        chk("t3_gap1_pre",  64'(preload_weight), 64'd0);
        step();
        chk("t3_gap2_pre",  64'(preload_weight), 64'd0);
        chk("t3_gap2_hold", 64'(weight_out),     64'(held));
        chk("t3_gap2_cnt",  64'(row_count),      64'd2);
        drive_row(1'b1, 32'h01020304, 1'b0);
        step();
        chk("t3_row2_pre", 64'(preload_weight), 64'b0100);
        drive_row(1'b1, 32'hFFFEFDFC, 1'b1);
        step();
        chk("t3_row3_pre", 64'(preload_weight), 64'b1000);
        drive_row(1'b0, '0, 1'b0);

        // Swap withheld for 10 cycles.
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t4_tile",  64'(tile_loaded),  64'd1);
            chk("t4_ready", 64'(weight_ready), 64'd0);
            chk("t4_load",  64'(load_weight),  64'd0);
            step();
        end
        swap_allowed = 1'b1;
        step();
        chk("t4_load_pulse", 64'(load_weight), 64'd1);
        step();
        chk("t4_load_done",  64'(load_weight), 64'd0);

        // Valid held across tile boundary.
        for (int i = 0; i < MW + 2; i++) begin
            drive_row(1'b1, MW*8'($urandom), 1'($urandom));
            step();
        end
        chk("t5_swap_load",  64'(load_weight),  64'd1);
        chk("t5_swap_ready", 64'(weight_ready), 64'd1);
        step();
        chk("t5_row0_pre", 64'(preload_weight), 64'b0001);
        chk("t5_row0_cnt", 64'(row_count),      64'd1);
        step();
        chk("t5_row1_pre", 64'(preload_weight), 64'b0010);

        // Reset after two rows.
        drive_row(1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_pre",  64'(preload_weight), 64'd0);
        chk("t6_wout", 64'(weight_out),     64'd0);
        chk("t6_cnt",  64'(row_count),      64'd0);
        chk("t6_load", 64'(load_weight),    64'd0);
        chk("t6_tile", 64'(tile_loaded),    64'd0);
        for (int i = 0; i < MW; i++) begin
            drive_row(1'b1, MW*8'($urandom), 1'($urandom));
            step();
            chk("t6_refill_pre", 64'(preload_weight), 64'(1 << i));
        end

        // Randomized run.
        for (int c = 0; c < 3000; c++) begin
            drive_row(1'($urandom_range(0, 9) < 7), MW*8'($urandom), 1'($urandom));
            swap_allowed = 1'($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        drive_row(1'b0, '0, 1'b0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
